// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 responder over a word-addressed SRAM; one read and one write burst in flight.
// Define AXI_SLV_RANGE_CHECK_EN to answer beats beyond the array with DECERR instead of aliasing.
module axi_sram_slave #(
  parameter int    MEM_AW        = 10,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  awid_i,
  input  logic [31:0] awaddr_i,
  input  logic [3:0]  awlen_i,
  input  logic [2:0]  awsize_i,
  input  logic [1:0]  awburst_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [3:0]  wid_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wlast_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [3:0]  bid_o,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i,
  input  logic [3:0]  arid_i,
  input  logic [31:0] araddr_i,
  input  logic [3:0]  arlen_i,
  input  logic [2:0]  arsize_i,
  input  logic [1:0]  arburst_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [3:0]  rid_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rlast_o,
  output logic        rvalid_o,
  input  logic        rready_i
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [1:0]  burst;
  } burst_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  logic [31:0] mem [0:(1<<MEM_AW)-1];

  // INCR and WRAP both step by one word; WRAP boundaries are not modelled.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] b);
    return (b == BURST_FIXED) ? a : a + 32'd4;
  endfunction

  logic unused_ok;
  assign unused_ok = ^{awsize_i, arsize_i, wid_i};

  // ---------------------------------------------------------------- write path
  wstate_t     wstate;
  burst_t      wb;
  logic [3:0]  wcnt;
  logic        werr, wdec;
  logic        w_fire, w_last_beat, w_oor;
  logic [MEM_AW-1:0] w_word;

  assign w_fire      = wvalid_i && wready_o;
  assign w_last_beat = (wcnt == wb.len);
  assign w_word      = wb.addr[MEM_AW+1:2];
  assign bid_o       = wb.id;

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate    <= W_IDLE;
      awready_o <= 1'b0;
      wready_o  <= 1'b0;
      bvalid_o  <= 1'b0;
      bresp_o   <= RESP_OKAY;
      wb        <= '0;
      wcnt      <= '0;
      werr      <= 1'b0;
      wdec      <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          awready_o <= 1'b1;
          if (awvalid_i && awready_o) begin
            wb        <= '{id: awid_i, addr: awaddr_i, len: awlen_i, burst: awburst_i};
            wcnt      <= '0;
            werr      <= 1'b0;
            wdec      <= 1'b0;
            awready_o <= 1'b0;
            wready_o  <= 1'b1;
            wstate    <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            wcnt    <= wcnt + 4'd1;
            wb.addr <= next_addr(wb.addr, wb.burst);
            // Beat count ends the burst; wlast only flags a protocol error.
            if (w_last_beat) begin
              wready_o <= 1'b0;
              bvalid_o <= 1'b1;
              if (wdec || w_oor)           bresp_o <= RESP_DECERR;
              else if (werr || !wlast_i)   bresp_o <= RESP_SLVERR;
              else                         bresp_o <= RESP_OKAY;
              wstate   <= W_RESP;
            end else begin
              if (wlast_i) werr <= 1'b1;
              if (w_oor)   wdec <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (bready_i) begin
            bvalid_o <= 1'b0;
            bresp_o  <= RESP_OKAY;
            wstate   <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_fire && !w_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) mem[w_word][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read path
  rstate_t     rstate;
  burst_t      rb;     // rb.addr is the address of the next beat to fetch
  logic [3:0]  rcnt;
  logic        r_fire, ar_oor, r_oor;

  assign r_fire = rvalid_o && rready_i;
  assign rid_o  = rb.id;

`ifdef AXI_SLV_RANGE_CHECK_EN
  assign w_oor  = |wb.addr[31:MEM_AW+2];
  assign ar_oor = |araddr_i[31:MEM_AW+2];
  assign r_oor  = |rb.addr[31:MEM_AW+2];
`else
  assign w_oor  = 1'b0;
  assign ar_oor = 1'b0;
  assign r_oor  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate    <= R_IDLE;
      arready_o <= 1'b0;
      rvalid_o  <= 1'b0;
      rlast_o   <= 1'b0;
      rdata_o   <= '0;
      rresp_o   <= RESP_OKAY;
      rb        <= '0;
      rcnt      <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          arready_o <= 1'b1;
          if (arvalid_i && arready_o) begin
            rb        <= '{id: arid_i, addr: next_addr(araddr_i, arburst_i),
                           len: arlen_i, burst: arburst_i};
            rcnt      <= '0;
            arready_o <= 1'b0;
            rvalid_o  <= 1'b1;
            rlast_o   <= (arlen_i == 4'd0);
            rdata_o   <= ar_oor ? '0 : mem[araddr_i[MEM_AW+1:2]];
            rresp_o   <= ar_oor ? RESP_DECERR : RESP_OKAY;
            rstate    <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_fire) begin
            if (rlast_o) begin
              rvalid_o <= 1'b0;
              rlast_o  <= 1'b0;
              rresp_o  <= RESP_OKAY;
              rstate   <= R_IDLE;
            end else begin
              // Fetch the following beat on the handshake edge for zero-bubble streaming.
              rcnt    <= rcnt + 4'd1;
              rb.addr <= next_addr(rb.addr, rb.burst);
              rlast_o <= ((rcnt + 4'd1) == rb.len);
              rdata_o <= r_oor ? '0 : mem[rb.addr[MEM_AW+1:2]];
              rresp_o <= r_oor ? RESP_DECERR : RESP_OKAY;
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed plus randomized bursts checked against a word-array memory model.
module tb_axi_sram_slave;
  localparam int MEM_AW = 10;
  localparam int WORDS  = 1 << MEM_AW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awid = '0, wid = '0, arid = '0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  awlen = '0, wstrb = '0, arlen = '0;
  logic [2:0]  awsize = 3'd2, arsize = 3'd2;
  logic [1:0]  awburst = 2'b01, arburst = 2'b01;
  logic        awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rlast, rvalid;
  logic [3:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  axi_sram_slave #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst),
    .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize),
    .awburst_i(awburst), .awvalid_i(awvalid), .awready_o(awready),
    .wid_i(wid), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast),
    .wvalid_i(wvalid), .wready_o(wready),
    .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize),
    .arburst_i(arburst), .arvalid_i(arvalid), .arready_o(arready),
    .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast),
    .rvalid_o(rvalid), .rready_i(rready)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] model [WORDS];
  logic [31:0] wq_data [$];
  logic [3:0]  wq_strb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] b, input int i);
    return (b == 2'b00) ? a : a + 32'(4 * i);
  endfunction

  function automatic bit oor(input logic [31:0] a);
`ifdef AXI_SLV_RANGE_CHECK_EN
    return a >= 32'(4 * WORDS);
`else
    return (a == 32'hFFFF_FFFF) && (a != a);
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % WORDS);
  endfunction

  task automatic aw_send(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = a; awlen = len; awburst = burst; awvalid = 1'b1;
    while (awready !== 1'b1 && n < 50) begin tick(); n++; end
    check("aw_ready", awready, 1);
    tick();
    awvalid = 1'b0; awaddr = $urandom;
  endtask

  task automatic w_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic last);
    int n = 0;
    repeat ($urandom_range(0, 1)) tick();
    wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    while (wready !== 1'b1 && n < 50) begin tick(); n++; end
    check("w_ready", wready, 1);
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    if (!oor(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic b_recv(input logic [3:0] id, input logic [1:0] exp_resp);
    int n = 0;
    repeat ($urandom_range(0, 2)) tick();
    while (bvalid !== 1'b1 && n < 50) begin tick(); n++; end
    check("b_valid", bvalid, 1);
    check("b_id", bid, id);
    check("b_resp", bresp, exp_resp);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("b_drop", bvalid, 0);
  endtask

  // Sends wq_data/wq_strb; bad_beat >= 0 flips wlast on that beat.
  task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                          input logic [1:0] burst, input int bad_beat);
    bit dec = 1'b0;
    logic [1:0] exp_resp;
    aw_send(id, a, len, burst);
    for (int i = 0; i <= int'(len); i++) begin
      logic [31:0] ba = beat_addr(a, burst, i);
      if (oor(ba)) dec = 1'b1;
      w_beat(ba, wq_data[i], wq_strb[i], (i == int'(len)) ^ (i == bad_beat));
    end
    exp_resp = dec ? 2'b11 : (bad_beat >= 0) ? 2'b10 : 2'b00;
    b_recv(id, exp_resp);
    wq_data.delete(); wq_strb.delete();
  endtask

  task automatic fill_w(input int n, input bit full_strb);
    for (int i = 0; i < n; i++) begin
      wq_data.push_back($urandom);
      wq_strb.push_back(full_strb ? 4'hF : 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [1:0] burst);
    int n = 0;
    arid = id; araddr = a; arlen = len; arburst = burst; arvalid = 1'b1;
    while (arready !== 1'b1 && n < 50) begin tick(); n++; end
    check("ar_ready", arready, 1);
    tick();
    arvalid = 1'b0; araddr = $urandom;
    check("r_first_valid", rvalid, 1);
  endtask

  // mode 0: rready held high, 1: random, 2: pattern 1,0,0 repeating
  task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [1:0] burst, input int mode);
    int beat = 0;
    int cyc = 0;
    ar_send(id, a, len, burst);
    while (beat <= int'(len) && cyc < 300) begin
      logic rr;
      logic [31:0] ba = beat_addr(a, burst, beat);
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (cyc % 3 == 0);
      rready = rr;
      check("r_valid", rvalid, 1);
      check("r_data", rdata, oor(ba) ? 32'h0 : model[widx(ba)]);
      check("r_last", rlast, beat == int'(len));
      if (rr) begin
        check("r_id", rid, id);
        check("r_resp", rresp, oor(ba) ? 2'b11 : 2'b00);
        beat++;
      end
      tick();
      cyc++;
    end
    rready = 1'b0;
    check("r_beats", beat, int'(len) + 1);
    check("r_done", rvalid, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rdata", rdata, 0);
    check("rst_bresp", bresp, 0);
    rst = 1'b0;
    tick();
    check("post_rst_awready", awready, 1);
    check("post_rst_arready", arready, 1);

    // Fill every word so the model is fully defined
    for (int blk = 0; blk < WORDS / 16; blk++) begin
      fill_w(16, 1'b1);
      do_write(4'(blk), 32'(blk * 64), 4'd15, 2'b01, -1);
    end

    // INCR round trip
    for (int i = 0; i < 4; i++) begin wq_data.push_back(32'hA0 + 32'(i)); wq_strb.push_back(4'hF); end
    do_write(4'd5, 32'h100, 4'd3, 2'b01, -1);
    do_read(4'd7, 32'h100, 4'd3, 2'b01, 0);

    // Byte strobes
    wq_data.push_back(32'h1122_3344); wq_strb.push_back(4'hF);
    do_write(4'd1, 32'h100, 4'd0, 2'b01, -1);
    wq_data.push_back(32'hAABB_CCDD); wq_strb.push_back(4'b0101);
    do_write(4'd2, 32'h100, 4'd0, 2'b01, -1);
    do_read(4'd3, 32'h100, 4'd0, 2'b01, 0);
    check("strobe_merge", rdata === 32'h0 ? 32'h0 : model[widx(32'h100)], 32'h11BB_33DD);

    // R backpressure
    do_read(4'd9, 32'h000, 4'd15, 2'b01, 2);
    do_read(4'd10, 32'h040, 4'd15, 2'b10, 1);

    // AW and AR on the same cycle, then FIXED bursts
    fill_w(4, 1'b1);
    fork
      do_write(4'd4, 32'h300, 4'd3, 2'b01, -1);
      do_read(4'd6, 32'h200, 4'd3, 2'b01, 0);
    join
    do_read(4'd6, 32'h300, 4'd3, 2'b01, 0);
    for (int i = 1; i <= 3; i++) begin wq_data.push_back(32'(i)); wq_strb.push_back(4'hF); end
    do_write(4'd8, 32'h80, 4'd2, 2'b00, -1);
    do_read(4'd8, 32'h80, 4'd2, 2'b00, 0);
    do_read(4'd8, 32'h7C, 4'd2, 2'b01, 0);

    // wlast errors: early on beat 2, and missing on the last beat
    fill_w(4, 1'b1);
    do_write(4'd11, 32'h140, 4'd3, 2'b01, 1);
    fill_w(4, 1'b1);
    do_write(4'd12, 32'h150, 4'd3, 2'b01, 3);
    do_read(4'd12, 32'h140, 4'd7, 2'b01, 0);

    // Reset during a read burst
    ar_send(4'd2, 32'h000, 4'd15, 2'b01);
    tick(); tick();
    check("midrd_valid", rvalid, 1);
    rst = 1'b1;
    tick();
    check("midrd_rst_rvalid", rvalid, 0);
    check("midrd_rst_arready", arready, 0);
    rst = 1'b0;
    tick();
    check("midrd_post_arready", arready, 1);
    do_read(4'd2, 32'h000, 4'd15, 2'b01, 0);

    // Reset during a write burst: first two beats stay written, no B
    aw_send(4'd3, 32'h180, 4'd3, 2'b01);
    w_beat(32'h180, 32'hDEAD_0000, 4'hF, 1'b0);
    w_beat(32'h184, 32'hDEAD_0001, 4'hF, 1'b0);
    rst = 1'b1;
    tick();
    check("midwr_rst_bvalid", bvalid, 0);
    check("midwr_rst_wready", wready, 0);
    rst = 1'b0;
    tick();
    check("midwr_post_awready", awready, 1);
    repeat (2) tick();
    check("midwr_no_b", bvalid, 0);
    do_read(4'd3, 32'h180, 4'd3, 2'b01, 1);

    // Address beyond the array: DECERR with the range check, aliasing without
    fill_w(1, 1'b1);
    do_write(4'd13, 32'h1000, 4'd0, 2'b01, -1);
    do_read(4'd13, 32'h0FFC, 4'd1, 2'b01, 0);
    do_read(4'd13, 32'h1000, 4'd0, 2'b01, 0);

    // Randomized bursts with random strobes, burst types and sub-word address bits
    for (int it = 0; it < 24; it++) begin
      logic [31:0] a   = $urandom & ((it % 4 == 0) ? 32'h1FFF : 32'h0FFF);
      logic [3:0]  len = 4'($urandom_range(0, 15));
      logic [1:0]  bt  = 2'($urandom_range(0, 2));
      fill_w(int'(len) + 1, 1'b0);
      do_write(4'($urandom), a, len, bt, -1);
      do_read(4'($urandom), a, len, bt, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
